blc_ob_accum: RTL
=================

// Module: blc_ob_accum
// PURPOSE
//  Optical-black (OB) statistics stage directly upstream of the pipelined divider.
//  Each frame it sums the raw pixels inside a programmable OB window and counts them.
//  After the last OB line it issues one request to the divider: dividend = sum, divisor = count.
//  The divider quotient is the mean black level used by the correction stage.
// PARAMETERS
//  PIX_W  10  raw pixel width
//  SUM_W  20  accumulator width; equals divider N
//  CNT_W  10  pixel-count width; equals divider M
//  XY_W   12  width of the internal column/row counters
//  OB_X0  0   first OB column (inclusive)
//  OB_X1  15  last OB column (inclusive)
//  OB_Y0  0   first OB row (inclusive)
//  OB_Y1  1   last OB row (inclusive)
// PORTS
//  clk       in   1      clock; all logic on rising edge
//  rst       in   1      asynchronous, active-high reset
//  pix_vld   in   1      pixel qualifier
//  sof       in   1      start of frame; valid only with pix_vld, marks pixel (0,0)
//  eol       in   1      end of line; valid only with pix_vld, marks last pixel of a row
//  pix_data  in   PIX_W  raw pixel value
//  data_rdy  out  1      1-cycle request pulse to the divider
//  dividend  out  SUM_W  OB pixel sum; stable from data_rdy until the next data_rdy
//  divisor   out  CNT_W  OB pixel count; stable from data_rdy until the next data_rdy
//  sum_sat   out  1      sticky per frame: sum or count saturated
//  ob_empty  out  1      sticky per frame: window held no pixels, so no request was issued
// BEHAVIOUR
//  Reset values: all outputs 0, x = y = 0, sum = cnt = 0, FSM in IDLE.
//  Position: each pix_vld increments x. pix_vld & eol sets x = 0 and increments y.
//    pix_vld & sof forces x = 1 and y = 0 for the next pixel; the sof pixel itself is at (0,0).
//  In-window test: OB_X0 <= x <= OB_X1 and OB_Y0 <= y <= OB_Y1, evaluated on the current pixel.
//  Accumulate: in-window pixel -> sum += pix_data, zero-extended, and cnt += 1.
//    Both saturate at all-ones; saturation sets sum_sat.
//  FSM states:
//    IDLE  : wait for sof.
//    ACCUM : collect OB pixels.
//    ISSUE : single cycle.
//    WAIT  : wait for the next sof.
//  FSM transitions:
//    IDLE  -> ACCUM on pix_vld & sof. That cycle clears sum, cnt, sum_sat and ob_empty,
//             then accumulates the sof pixel if it is in the window.
//    ACCUM -> ISSUE on pix_vld & eol with y == OB_Y1, after that pixel is included.
//    ISSUE -> WAIT after one cycle.
//             If cnt != 0: dividend <= sum, divisor <= cnt, and data_rdy is 1 for exactly this cycle.
//             If cnt == 0: set ob_empty; data_rdy stays 0 and dividend/divisor keep their old values.
//    WAIT  -> ACCUM on pix_vld & sof, with the same clearing as from IDLE.
//  Latency: data_rdy is asserted 1 cycle after the eol pixel of row OB_Y1 is sampled.
//  No back-pressure: the divider accepts one request every cycle, so requests are never dropped.
//  Boundary cases:
//    sof during ACCUM: abort the frame; clear and restart with the sof pixel, no request.
//    sof during ISSUE: the request completes; the sof is processed in WAIT on the next cycle.
//      Hold it in a 1-deep pending flag so no pixel is lost.
//    sof & eol in the same cycle: handle sof first, then eol (single-pixel row).
//    x and y saturate at all-ones; a huge frame never wraps back into the window.
//    pix_vld = 0: no state change other than the FSM ISSUE -> WAIT step.
//    rst asserted mid-frame: immediate return to the reset values; the next sof starts clean.
// STRUCTURE
//  Shared package blc_pkg holds: PIX_W/SUM_W/CNT_W defaults, the OB window constants,
//  and the FSM state encoding (IDLE = 0, ACCUM = 1, ISSUE = 2, WAIT = 3).
//  One natural sub-module: blc_pos_cnt, the x/y counter with sof/eol handling and
//  saturation, which outputs x, y and in_win.
//  The top level holds the FSM, the accumulator and the output registers.
//  Connects straight to divider(N = SUM_W, M = CNT_W) data_rdy/dividend/divisor.
// TESTING
//  T1: 4x2 OB window, defaults adjusted, all pixels 64 -> one data_rdy; dividend = 512, divisor = 8.
//  T2: OB window 16x2 with pixels = x (0..15) on both rows -> dividend = 240, divisor = 32;
//      data_rdy exactly 1 cycle after the row-1 eol.
//  T3: PIX_W = 10 with all pixels 1023 and SUM_W = 12 -> sum sticks at 4095 and sum_sat = 1;
//      request still issued.
//  T4: OB_X0 beyond the line length -> no data_rdy, ob_empty = 1; previous dividend/divisor unchanged.
//  T5: second sof after 5 OB pixels -> no request for the aborted frame;
//      the next full frame gives a correct sum and count.
//  T6: rst pulsed mid-ACCUM, then a full frame -> all outputs 0 after rst;
//      a single correct request afterwards with no stale contribution.

Source files
------------

// File: rtl/blc_pkg.sv
// rtl/blc_pkg.sv - shared widths, OB window defaults and FSM encoding for the black-level stage
package blc_pkg;

    localparam int BLC_PIX_W = 10;
    localparam int BLC_SUM_W = 20;
    localparam int BLC_CNT_W = 10;
    localparam int BLC_XY_W  = 12;

    localparam int BLC_OB_X0 = 0;
    localparam int BLC_OB_X1 = 15;
    localparam int BLC_OB_Y0 = 0;
    localparam int BLC_OB_Y1 = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } blc_state_t;

endpackage

// File: rtl/blc_pos_cnt.sv
// rtl/blc_pos_cnt.sv - saturating pixel column/row tracker with OB window flag
module blc_pos_cnt
    import blc_pkg::*;
#(
    parameter int XY_W  = BLC_XY_W,
    parameter int OB_X0 = BLC_OB_X0,
    parameter int OB_X1 = BLC_OB_X1,
    parameter int OB_Y0 = BLC_OB_Y0,
    parameter int OB_Y1 = BLC_OB_Y1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pix_vld,
    input  logic            sof,
    input  logic            eol,
    output logic [XY_W-1:0] y,
    output logic            in_win
);

    logic [XY_W-1:0] x_q;
    logic [XY_W-1:0] y_q;
    logic [XY_W-1:0] x;
    logic            sof_v;

    function automatic logic [XY_W-1:0] sat_inc(input logic [XY_W-1:0] v);
        return (&v) ? v : v + XY_W'(1);
    endfunction

    // sof relocates the current pixel to (0,0); eol is then applied on top of it
    assign sof_v  = pix_vld & sof;
    assign x      = sof_v ? '0 : x_q;
    assign y      = sof_v ? '0 : y_q;
    assign in_win = (int'(x) >= OB_X0) && (int'(x) <= OB_X1) &&
                    (int'(y) >= OB_Y0) && (int'(y) <= OB_Y1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (pix_vld) begin
            if (eol) begin
                x_q <= '0;
                y_q <= sat_inc(y);
            end else begin
                x_q <= sat_inc(x);
                y_q <= y;
            end
        end
    end

endmodule

// File: rtl/blc_ob_accum.sv
// rtl/blc_ob_accum.sv - per-frame OB window sum/count with one divider request per frame
module blc_ob_accum
    import blc_pkg::*;
#(
    parameter int PIX_W = BLC_PIX_W,
    parameter int SUM_W = BLC_SUM_W,
    parameter int CNT_W = BLC_CNT_W,
    parameter int XY_W  = BLC_XY_W,
    parameter int OB_X0 = BLC_OB_X0,
    parameter int OB_X1 = BLC_OB_X1,
    parameter int OB_Y0 = BLC_OB_Y0,
    parameter int OB_Y1 = BLC_OB_Y1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_vld,
    input  logic             sof,
    input  logic             eol,
    input  logic [PIX_W-1:0] pix_data,
    output logic             data_rdy,
    output logic [SUM_W-1:0] dividend,
    output logic [CNT_W-1:0] divisor,
    output logic             sum_sat,
    output logic             ob_empty
);

    blc_state_t      state;
    logic [SUM_W-1:0] sum, base_sum, acc_sum;
    logic [CNT_W-1:0] cnt, base_cnt, acc_cnt;
    logic [SUM_W:0]   sum_ext;
    logic [XY_W-1:0]  y;
    logic             in_win, start, add, acc_sat, last_eol, pend;

    blc_pos_cnt #(
        .XY_W (XY_W),
        .OB_X0(OB_X0),
        .OB_X1(OB_X1),
        .OB_Y0(OB_Y0),
        .OB_Y1(OB_Y1)
    ) u_pos (
        .clk    (clk),
        .rst    (rst),
        .pix_vld(pix_vld),
        .sof    (sof),
        .eol    (eol),
        .y      (y),
        .in_win (in_win)
    );

    assign start    = pix_vld & sof;
    assign add      = pix_vld & in_win;
    assign last_eol = pix_vld & eol & (int'(y) == OB_Y1);
    assign base_sum = start ? '0 : sum;
    assign base_cnt = start ? '0 : cnt;
    assign sum_ext  = {1'b0, base_sum} + (SUM_W+1)'(pix_data);

    always_comb begin
        acc_sum = base_sum;
        acc_cnt = base_cnt;
        acc_sat = 1'b0;
        if (add) begin
            acc_sum = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
            acc_cnt = (&base_cnt) ? base_cnt : base_cnt + CNT_W'(1);
            acc_sat = sum_ext[SUM_W] | (&base_cnt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            sum      <= '0;
            cnt      <= '0;
            pend     <= 1'b0;
            data_rdy <= 1'b0;
            dividend <= '0;
            divisor  <= '0;
            sum_sat  <= 1'b0;
            ob_empty <= 1'b0;
        end else begin
            data_rdy <= 1'b0;
            if (state == ST_ISSUE) begin
                if (cnt != '0) begin
                    data_rdy <= 1'b1;
                    dividend <= sum;
                    divisor  <= cnt;
                end else begin
                    ob_empty <= 1'b1;
                end
                state <= ST_WAIT;
                // a sof landing on the issue cycle seeds the next frame; flags clear in WAIT
                if (start) begin
                    pend <= 1'b1;
                    sum  <= acc_sum;
                    cnt  <= acc_cnt;
                end
            end else if (start || (state == ST_WAIT && pend)) begin
                pend     <= 1'b0;
                sum      <= acc_sum;
                cnt      <= acc_cnt;
                sum_sat  <= acc_sat;
                ob_empty <= 1'b0;
                state    <= last_eol ? ST_ISSUE : ST_ACCUM;
            end else if (state == ST_ACCUM && pix_vld) begin
                sum <= acc_sum;
                cnt <= acc_cnt;
                if (acc_sat) sum_sat <= 1'b1;
                if (last_eol) state <= ST_ISSUE;
            end
        end
    end

endmodule
